// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the MIPS load/store unit.
package mips_lsu_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd7,
    SH  = 4'd8,
    SW  = 4'd9,
    SWL = 4'd10,
    SWR = 4'd11
  } lsu_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_BUS   = 3'd2,
    S_RDATA = 3'd3,
    S_DONE  = 3'd4
  } lsu_state_t;

  function automatic logic is_load(input lsu_op_t op);
    return (op inside {LB, LBU, LH, LHU, LW, LWL, LWR});
  endfunction

  // Halfwords must sit on even offsets, full words on offset 0.
  // LWL/LWR/SWL/SWR exist precisely to handle unaligned words.
  function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] off);
    case (op)
      LH, LHU, SH: return off[0];
      LW, SW:      return (off != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_avalon_if.sv
// Request/response and Avalon-MM signals of the load/store unit.
//
// Request handshake: a request transfers on a rising edge where both
// req_valid and req_ready are high; req_ready is high only while the unit is
// idle, and request fields are don't-care at every other edge. The response
// is a single-cycle resp_valid pulse with no back-pressure. On the Avalon
// side the transfer completes on the first edge with avm_read or avm_write
// high and avm_waitrequest low; readdata is valid one cycle after that.
interface mips_lsu_avalon_if
  import mips_lsu_pkg::*;
#(
  parameter int REG_ADDR_W = 5
);
  logic                  req_valid;
  logic                  req_ready;
  lsu_op_t               req_op;
  logic [31:0]           req_base;
  logic [15:0]           req_offset;
  logic [31:0]           req_rt_data;
  logic [REG_ADDR_W-1:0] req_rt_idx;

  logic                  resp_valid;
  logic                  resp_reg_we;
  logic [REG_ADDR_W-1:0] resp_reg_idx;
  logic [31:0]           resp_reg_wdata;
  logic                  resp_addr_err;
  logic                  resp_bus_err;

  logic [31:0]           avm_address;
  logic [3:0]            avm_byteenable;
  logic                  avm_read;
  logic                  avm_write;
  logic [31:0]           avm_writedata;
  logic [31:0]           avm_readdata;
  logic                  avm_waitrequest;

  // master: the load/store unit (drives responses and the Avalon master side)
  modport master (
    input  req_valid, req_op, req_base, req_offset, req_rt_data, req_rt_idx,
    output req_ready,
    output resp_valid, resp_reg_we, resp_reg_idx, resp_reg_wdata,
    output resp_addr_err, resp_bus_err,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  // slave: control FSM plus memory slave seen from the other side
  modport slave (
    output req_valid, req_op, req_base, req_offset, req_rt_data, req_rt_idx,
    input  req_ready,
    input  resp_valid, resp_reg_we, resp_reg_idx, resp_reg_wdata,
    input  resp_addr_err, resp_bus_err,
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/mips_lsu_lane.sv
// Byte-lane steering: byteenables, positioned store data and the
// extended/merged load result for one op at a given byte offset.
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  offset,
  input  logic        big_endian,
  input  logic [31:0] rt_data,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_data
);
  logic [1:0]  lane_b;   // lane holding the byte at 'offset'
  logic        hi_half;  // halfword lives in lanes 3:2
  logic [1:0]  sl;       // LWL/SWL: bytes taken from rt (register low end)
  logic [1:0]  sr;       // LWR/SWR: bytes kept from rt (register high end)
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] wd_raw;
  logic [31:0] be_mask;

  // All lane selection, store positioning and load merging in one pass.
  always_comb begin
    lane_b  = big_endian ? (2'd3 - offset) : offset;
    hi_half = offset[1] ^ big_endian;
    sl      = big_endian ? offset : (2'd3 - offset);
    sr      = big_endian ? (2'd3 - offset) : offset;
    rd_byte = readdata[{lane_b, 3'b000} +: 8];
    rd_half = hi_half ? readdata[31:16] : readdata[15:0];

    case (op)
      LB, LBU, SB: byteenable = 4'b0001 << lane_b;
      LH, LHU, SH: byteenable = hi_half ? 4'b1100 : 4'b0011;
      LWL, SWL:    byteenable = 4'b1111 >> sl;
      LWR, SWR:    byteenable = 4'b1111 << sr;
      default:     byteenable = 4'b1111;
    endcase

    be_mask = {{8{byteenable[3]}}, {8{byteenable[2]}},
               {8{byteenable[1]}}, {8{byteenable[0]}}};

    // Replicate small stores across the word, shift partial-word stores;
    // the byteenable mask then zeroes every lane that is not written.
    case (op)
      SB:      wd_raw = {4{rt_data[7:0]}};
      SH:      wd_raw = {2{rt_data[15:0]}};
      SWL:     wd_raw = rt_data >> {sl, 3'b000};
      SWR:     wd_raw = rt_data << {sr, 3'b000};
      default: wd_raw = rt_data;
    endcase
    writedata = is_load(op) ? 32'h0 : (wd_raw & be_mask);

    case (op)
      LB:      load_data = {{24{rd_byte[7]}}, rd_byte};
      LBU:     load_data = {24'h0, rd_byte};
      LH:      load_data = {{16{rd_half[15]}}, rd_half};
      LHU:     load_data = {16'h0, rd_half};
      LW:      load_data = readdata;
      LWL:     load_data = (readdata << {sl, 3'b000})
                         | (rt_data & ~(32'hFFFF_FFFF << {sl, 3'b000}));
      LWR:     load_data = (readdata >> {sr, 3'b000})
                         | (rt_data & ~(32'hFFFF_FFFF >> {sr, 3'b000}));
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mips_lsu_avalon.sv
// Load/store unit: accepts one request, runs one Avalon-MM transfer with
// waitrequest stall and timeout, returns a single-cycle writeback response.
module mips_lsu_avalon
  import mips_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int REG_ADDR_W     = 5
)(
  input  logic       clk,
  input  logic       reset_n,
  mips_lsu_avalon_if.master bus,
  output lsu_state_t dbg_state
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_t            state_q, state_d;
  lsu_op_t               op_q;
  logic [31:0]           ea_q;
  logic [31:0]           rt_q;
  logic [REG_ADDR_W-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  addr_err_q, bus_err_q;
  logic [TW-1:0]         to_cnt;

  logic [31:0]           avm_address_q, avm_writedata_q;
  logic [3:0]            avm_be_q;
  logic                  avm_read_q, avm_write_q;

  logic [31:0]           ea;
  logic                  misaligned;
  logic                  timeout_hit;
  logic [3:0]            lane_be;
  logic [31:0]           lane_wd, lane_ld;

  assign ea          = bus.req_base + {{16{bus.req_offset[15]}}, bus.req_offset};
  assign misaligned  = is_misaligned(op_q, ea_q[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == S_BUS)
                    && bus.avm_waitrequest && (to_cnt == TO_LAST);

  mips_lsu_lane u_lane (
    .op         (op_q),
    .offset     (ea_q[1:0]),
    .big_endian (BIG_ENDIAN),
    .rt_data    (rt_q),
    .readdata   (bus.avm_readdata),
    .byteenable (lane_be),
    .writedata  (lane_wd),
    .load_data  (lane_ld)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = S_CHECK;
      S_CHECK: state_d = misaligned ? S_DONE : S_BUS;
      S_BUS: begin
        if (!bus.avm_waitrequest) state_d = is_load(op_q) ? S_RDATA : S_DONE;
        else if (timeout_hit)     state_d = S_DONE;
      end
      S_RDATA: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, registered Avalon outputs, result and error flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q            <= LB;
      ea_q            <= '0;
      rt_q            <= '0;
      idx_q           <= '0;
      wdata_q         <= '0;
      addr_err_q      <= 1'b0;
      bus_err_q       <= 1'b0;
      avm_address_q   <= '0;
      avm_be_q        <= '0;
      avm_writedata_q <= '0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q       <= bus.req_op;
            ea_q       <= ea;
            rt_q       <= bus.req_rt_data;
            idx_q      <= bus.req_rt_idx;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
          end
        end
        S_CHECK: begin
          if (misaligned) begin
            addr_err_q <= 1'b1;
          end else begin
            avm_address_q   <= {ea_q[31:2], 2'b00};
            avm_be_q        <= lane_be;
            avm_writedata_q <= lane_wd;
            avm_read_q      <= is_load(op_q);
            avm_write_q     <= !is_load(op_q);
          end
        end
        S_BUS: begin
          // Leave the bus either on acceptance or on timeout abort.
          if (!bus.avm_waitrequest || timeout_hit) begin
            avm_address_q   <= '0;
            avm_be_q        <= '0;
            avm_writedata_q <= '0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            bus_err_q       <= bus.avm_waitrequest;
          end
        end
        S_RDATA: wdata_q <= lane_ld;
        default: ;
      endcase
    end
  end

  // Stall counter: counts consecutive waitrequest cycles inside BUS only.
  always_ff @(posedge clk) begin
    if (!reset_n) to_cnt <= '0;
    else if (state_q == S_BUS && bus.avm_waitrequest && !timeout_hit) to_cnt <= to_cnt + 1'b1;
    else to_cnt <= '0;
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.resp_valid     = (state_q == S_DONE);
  assign bus.resp_reg_we    = (state_q == S_DONE) && is_load(op_q) && !addr_err_q && !bus_err_q;
  assign bus.resp_reg_idx   = (state_q == S_DONE) ? idx_q : '0;
  assign bus.resp_reg_wdata = (state_q == S_DONE) ? wdata_q : '0;
  assign bus.resp_addr_err  = (state_q == S_DONE) && addr_err_q;
  assign bus.resp_bus_err   = (state_q == S_DONE) && bus_err_q;

  assign bus.avm_address    = avm_address_q;
  assign bus.avm_byteenable = avm_be_q;
  assign bus.avm_read       = avm_read_q;
  assign bus.avm_write      = avm_write_q;
  assign bus.avm_writedata  = avm_writedata_q;

  assign dbg_state = state_q;

endmodule
